// File: rtl/router_pkt_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Optional parity corruption is enabled by ROUTER_PKT_TX_PARITY_CORRUPT_EN.
package router_pkt_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'd3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_HDR,
        TX_PLD,
        TX_PAR,
        TX_WAIT
    } tx_state_e;

    function automatic logic [DATA_W-1:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Single-clock show-ahead FIFO holding one packet payload.
// Pointers and occupancy clear asynchronously; storage is not reset.
module router_tx_buf #(
    parameter int DEPTH = 63,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          wr;
    logic          rd;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign wr        = wr_en_i && !full_o;
    assign rd        = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) begin
                wptr_q <= (wptr_q == AW'(DEPTH-1)) ? '0 : wptr_q + AW'(1);
            end
            if (rd) begin
                rptr_q <= (rptr_q == AW'(DEPTH-1)) ? '0 : rptr_q + AW'(1);
            end
            unique case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Router source-port packet transmitter: buffer payload, send hdr/pld/parity.
// Define ROUTER_PKT_TX_PARITY_CORRUPT_EN to add the corrupt_par input.
module router_pkt_tx
    import router_pkt_pkg::*;
#(
    parameter int ERR_WAIT = 3,
    parameter int MAX_LEN  = 63
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              pld_valid,
    output logic              pld_ready,
    input  logic [DATA_W-1:0] pld_data,
    input  logic              busy,
    input  logic              err,
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    input  logic              corrupt_par,
`endif
    output logic [DATA_W-1:0] data_in,
    output logic              pkt_valid,
    output logic              done,
    output logic              done_err,
    output logic              bad_cmd
);

    tx_state_e         state_q;
    logic [DATA_W-1:0] hdr_q;
    logic [DATA_W-1:0] par_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [3:0]        wait_q;
    logic              sticky_q;
    logic [DATA_W-1:0] data_in_q;
    logic              pkt_valid_q;
    logic              done_q;
    logic              done_err_q;
    logic              bad_cmd_q;
    logic              corrupt_q;

    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              buf_empty;
    logic              buf_full;

    assign cmd_ready = (state_q == TX_IDLE);
    assign pld_ready = (state_q == TX_LOAD);
    assign wr_en     = pld_ready && pld_valid && !buf_full;
    assign rd_en     = !busy && ((state_q == TX_HDR) ||
                                 (state_q == TX_PLD && !buf_empty));

    assign data_in   = data_in_q;
    assign pkt_valid = pkt_valid_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign bad_cmd   = bad_cmd_q;

`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            corrupt_q <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            corrupt_q <= corrupt_par;
        end
    end
`else
    assign corrupt_q = 1'b0;
`endif

    router_tx_buf #(
        .DEPTH (MAX_LEN),
        .DW    (DATA_W)
    ) u_buf (
        .clk_i     (clock),
        .rst_ni    (resetn),
        .wr_en_i   (wr_en),
        .wr_data_i (pld_data),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .empty_o   (buf_empty),
        .full_o    (buf_full)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= TX_IDLE;
            hdr_q       <= '0;
            par_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            sticky_q    <= 1'b0;
            data_in_q   <= '0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            bad_cmd_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            bad_cmd_q  <= 1'b0;
            unique case (state_q)
                TX_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_addr == ILLEGAL_ADDR || cmd_len == '0) begin
                            bad_cmd_q <= 1'b1;
                        end else begin
                            hdr_q   <= make_header(cmd_len, cmd_addr);
                            par_q   <= make_header(cmd_len, cmd_addr);
                            len_q   <= cmd_len;
                            cnt_q   <= '0;
                            state_q <= TX_LOAD;
                        end
                    end
                end
                TX_LOAD: begin
                    if (wr_en) begin
                        par_q <= par_q ^ pld_data;
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            data_in_q   <= hdr_q;
                            pkt_valid_q <= 1'b1;
                            state_q     <= TX_HDR;
                        end
                    end
                end
                TX_HDR: begin
                    if (!busy) begin
                        data_in_q <= rd_data;
                        state_q   <= TX_PLD;
                    end
                end
                TX_PLD: begin
                    if (!busy) begin
                        if (!buf_empty) begin
                            data_in_q <= rd_data;
                        end else begin
                            data_in_q   <= par_q ^ {7'b0, corrupt_q};
                            pkt_valid_q <= 1'b0;
                            state_q     <= TX_PAR;
                        end
                    end
                end
                TX_PAR: begin
                    if (!busy) begin
                        data_in_q <= '0;
                        wait_q    <= 4'(ERR_WAIT - 1);
                        sticky_q  <= 1'b0;
                        state_q   <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    // err on the final window cycle still counts
                    if (wait_q == '0) begin
                        done_q     <= 1'b1;
                        done_err_q <= sticky_q | err;
                        state_q    <= TX_IDLE;
                    end else begin
                        wait_q   <= wait_q - 4'd1;
                        sticky_q <= sticky_q | err;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: wire bytes and done status.
module tb_router_pkt_tx;
    import router_pkt_pkg::*;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_addr = '0;
    logic [5:0] cmd_len = '0;
    logic       pld_valid = 1'b0;
    logic       pld_ready;
    logic [7:0] pld_data = '0;
    logic       busy = 1'b0;
    logic       err = 1'b0;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       done;
    logic       done_err;
    logic       bad_cmd;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    logic       corrupt_par = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    logic done_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   par_cyc = 0;
    bit   in_pkt = 1'b0;

    always #5 clock = ~clock;

    router_pkt_tx #(
        .ERR_WAIT (3),
        .MAX_LEN  (63)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .pld_valid (pld_valid),
        .pld_ready (pld_ready),
        .pld_data  (pld_data),
        .busy      (busy),
        .err       (err),
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        .corrupt_par (corrupt_par),
`endif
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .done      (done),
        .done_err  (done_err),
        .bad_cmd   (bad_cmd)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a byte is taken by the router on each non-busy edge
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (!resetn) begin
            in_pkt = 1'b0;
        end else begin
            if (!busy && (pkt_valid || in_pkt)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'({pkt_valid, data_in}), 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("wire_byte", 32'({pkt_valid, data_in}), 32'({e.v, e.d}));
                end
                if (pkt_valid) begin
                    in_pkt = 1'b1;
                end else begin
                    in_pkt = 1'b0;
                    par_cyc = cyc;
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    chk("done_err", 32'(done_err), 32'(done_q.pop_front()));
                    chk("done_latency", 32'(cyc - par_cyc), 32'(4));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load_pkt(input logic [1:0] a, input logic [5:0] l,
                            input logic [7:0] d[$]);
        int k;
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < int'(l); i++) begin
            pld_valid = 1'b1;
            pld_data  = d[i];
            k = 0;
            while (!pld_ready && k < 50) begin
                @(posedge clock); #1;
                k++;
            end
            if (!pld_ready) chk("pld_ready_wait", 32'(pld_ready), 32'(1));
            @(posedge clock); #1;
        end
        pld_valid = 1'b0;
        chk("pld_ready_drop", 32'(pld_ready), 32'(0));
    endtask

    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l,
                            input logic [7:0] d[$],
                            input logic [7:0] ehdr, input logic [7:0] epar,
                            input int busy_at, input int busy_n,
                            input int err_at, input logic ederr);
        int p;
        exp_q.push_back('{d: ehdr, v: 1'b1});
        for (int i = 0; i < int'(l); i++) exp_q.push_back('{d: d[i], v: 1'b1});
        exp_q.push_back('{d: epar, v: 1'b0});
        done_q.push_back(ederr);
        load_pkt(a, l, d);
        p = int'(l) + 1 + busy_n;
        for (int t = 0; t <= p + 8; t++) begin
            busy = (busy_at >= 0) && (t >= busy_at) && (t < busy_at + busy_n);
            err  = (t == err_at);
            if (t == 0)
                chk("hdr_latency", 32'({pkt_valid, data_in}), 32'({1'b1, ehdr}));
            if (busy_n > 0 && t >= busy_at && t <= busy_at + busy_n)
                chk("busy_hold", 32'(data_in), 32'(d[busy_at-1]));
            @(posedge clock); #1;
        end
        busy = 1'b0;
        err  = 1'b0;
    endtask

    initial begin
        logic [7:0] pl[$];

        repeat (3) @(posedge clock);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_pld_ready", 32'(pld_ready), 32'(0));
        chk("rst_pkt_valid", 32'(pkt_valid), 32'(0));
        chk("rst_data_in", 32'(data_in), 32'(0));
        chk("rst_done", 32'({done, done_err}), 32'(0));
        chk("rst_bad_cmd", 32'(bad_cmd), 32'(0));
        resetn = 1'b1;

        pl.delete();
        pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        send_pkt(2'd1, 6'd3, pl, 8'h0D, 8'h0D, -1, 0, -1, 1'b0);
        send_pkt(2'd1, 6'd3, pl, 8'h0D, 8'h0D, 2, 2, -1, 1'b0);

        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 2'd3;
        cmd_len   = 6'd5;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        pld_valid = 1'b1;
        chk("bad_addr_pulse", 32'(bad_cmd), 32'(1));
        chk("bad_addr_pld_ready", 32'(pld_ready), 32'(0));
        chk("bad_addr_cmd_ready", 32'(cmd_ready), 32'(1));
        @(posedge clock); #1;
        chk("bad_addr_pulse_end", 32'(bad_cmd), 32'(0));
        chk("bad_addr_pkt_valid", 32'(pkt_valid), 32'(0));
        pld_valid = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 2'd1;
        cmd_len   = 6'd0;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        chk("bad_len_pulse", 32'(bad_cmd), 32'(1));
        chk("bad_len_cmd_ready", 32'(cmd_ready), 32'(1));

        pl.delete();
        for (int i = 0; i < 63; i++) pl.push_back(8'(i));
        send_pkt(2'd2, 6'd63, pl, 8'hFE, 8'hC1, -1, 0, -1, 1'b0);

        pl.delete();
        pl.push_back(8'h5A); pl.push_back(8'hA5);
        send_pkt(2'd0, 6'd2, pl, 8'h08, 8'hF7, -1, 0, 5, 1'b1);
        send_pkt(2'd0, 6'd2, pl, 8'h08, 8'hF7, -1, 0, 9, 1'b0);

        // abort during the second payload byte
        pl.delete();
        pl.push_back(8'hAA); pl.push_back(8'hBB); pl.push_back(8'hCC);
        exp_q.push_back('{d: 8'h0C, v: 1'b1});
        exp_q.push_back('{d: 8'hAA, v: 1'b1});
        exp_q.push_back('{d: 8'hBB, v: 1'b1});
        load_pkt(2'd0, 6'd3, pl);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("abort_second_byte", 32'({pkt_valid, data_in}), 32'h1BB);
        @(negedge clock); #1;
        resetn = 1'b0;
        #1;
        chk("abort_pkt_valid", 32'(pkt_valid), 32'(0));
        chk("abort_data_in", 32'(data_in), 32'(0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        chk("abort_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("abort_queue_drained", 32'(exp_q.size()), 32'(0));
        repeat (8) @(posedge clock);
        #1;
        chk("abort_no_done", 32'(done_q.size()), 32'(0));

        pl.delete();
        pl.push_back(8'h7E);
        send_pkt(2'd2, 6'd1, pl, 8'h06, 8'h78, -1, 0, -1, 1'b0);

        repeat (10) @(posedge clock);
        #1;
        chk("final_bytes_left", 32'(exp_q.size()), 32'(0));
        chk("final_done_left", 32'(done_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Hardware packet source for the 1x3 router. It accepts a command (destination address, payload length) and the payload bytes, then buffers the whole payload. It drives data_in/pkt_valid into the router source port: header, then payload, then parity, honouring busy. Afterwards it samples err and reports per-packet completion status; it sits wherever an on-chip agent feeds the router.

Parameters:
ERR_WAIT, 3, cycles after the parity byte during which router err is sampled (1..15)
MAX_LEN, 63, maximum payload length; also the internal buffer depth

Ports:
clock  in  1  system clock, all logic on posedge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_addr  in  2  destination port 0..2; 3 is illegal
cmd_len  in  6  payload byte count 1..MAX_LEN; 0 is illegal
pld_valid  in  1  payload byte valid
pld_ready  out  1  high only in LOAD
pld_data  in  8  payload byte
busy  in  1  router busy; the transmitter holds its outputs while high
err  in  1  router parity-error indication
data_in  out  8  byte to router (registered)
pkt_valid  out  1  packet-valid to router (registered)
done  out  1  one-cycle pulse at packet completion
done_err  out  1  valid with done; 1 if err was seen
bad_cmd  out  1  one-cycle pulse when an illegal command is dropped

Behaviour:
- Reset (async, resetn=0): state IDLE, data_in=0, pkt_valid=0, done=0, done_err=0, bad_cmd=0, buffer emptied. cmd_ready=1 and pld_ready=0 are decoded from state. Reset asserted mid-packet aborts immediately: pkt_valid drops asynchronously and no done is issued.
- States: IDLE, LOAD, HDR, PLD, PAR, WAIT.
- IDLE:
  - On cmd_valid&&cmd_ready: latch addr/len and set header = {len,addr}. Go to LOAD.
  - If addr==3 or len==0: pulse bad_cmd next cycle and stay in IDLE.
- LOAD:
  - Each pld_valid&&pld_ready writes one byte to the buffer and XORs it into the running parity, which is seeded with the header.
  - When the last byte is written, go to HDR. On that same clock edge, register data_in=header and pkt_valid=1.
- Output advance rule: on any posedge in HDR/PLD/PAR with busy==1, data_in, pkt_valid and state hold; nothing advances.
- HDR → PLD: data_in = first buffer byte, pkt_valid=1.
- PLD: one byte per non-busy edge. After the last byte, go to PAR with data_in=parity and pkt_valid=0.
- PAR: on a non-busy edge, go to WAIT with data_in=0, a counter loaded with ERR_WAIT, and sticky err flag cleared.
- WAIT:
  - Each cycle, err==1 sets the sticky flag.
  - When the counter reaches 0: pulse done, set done_err=sticky, return to IDLE.
- Latency, busy low: header on the cycle after the last payload write. Total wire bytes = len+2 over len+2 cycles. done follows the parity byte by ERR_WAIT+1 cycles.
- busy is ignored in IDLE, LOAD and WAIT. err is ignored outside WAIT.
- The buffer never overflows because LOAD accepts exactly len bytes; pld_ready is 0 in every other state.

Optional Feature:
ROUTER_PKT_TX_PARITY_CORRUPT_EN
- With it defined: extra input corrupt_par (1 bit), sampled at command acceptance. If set, the transmitted parity byte has bit 0 inverted, for error injection.
- Without it: the port is absent and the parity is always correct.

Decomposition:
- Package router_pkt_pkg holds:
  - state enum tx_state_e
  - ADDR_W=2, LEN_W=6, DATA_W=8
  - ILLEGAL_ADDR=2'd3
  - function make_header(len,addr)
- Sub-module router_tx_buf: synchronous single-clock FIFO, depth MAX_LEN, with write/read enables, empty, full, and async clear on resetn.

Test Plan:
1. addr=1, len=3, payload 11,22,33, busy=0 → data_in 0D,11,22,33 with pkt_valid=1, then 0D with pkt_valid=0; done at parity+4 cycles (ERR_WAIT=3); done_err=0.
2. Same packet, busy=1 for 2 cycles while 22 is on data_in → 22 held 3 cycles, then 33 and 0D; parity unchanged.
3. cmd_addr=3, len=5 → bad_cmd pulse; pld_ready stays 0; pkt_valid never asserts; cmd_ready stays 1.
4. addr=2, len=63, payload 00..3E → 65 wire bytes; header FE; pld_ready drops after the 63rd write; parity equals FE XOR all payload bytes.
5. err pulsed 2 cycles after the parity byte → done_err=1; err pulsed 6 cycles after → done_err=0.
6. resetn=0 during the 2nd payload byte → pkt_valid=0 and data_in=0 immediately; no done; after release cmd_ready=1 and a new packet transmits correctly.
